// File: rtl/gcm_pkg.sv
// Shared constants and types for the digit-serial GHASH multiplier.
// GCM bit order: GCM bit 0 is vector bit 127.
package gcm_pkg;

   localparam int BLOCK_W = 128;
   localparam logic [BLOCK_W-1:0] GCM_R = {8'hE1, 120'h0};

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MULT = 1'b1
   } gcm_state_e;

   function automatic bit gcm_digit_w_ok(input int w);
      return (w == 1) || (w == 2) || (w == 4) || (w == 8) || (w == 16);
   endfunction

endpackage

// File: rtl/gcm_gf_digit_step.sv
// One clock's worth of GF(2^128) shift-and-add.
// Consumes DIGIT_W multiplier bits, MSB first.
module gcm_gf_digit_step
   import gcm_pkg::*;
#(
   parameter int DIGIT_W = 1
) (
   input  logic [BLOCK_W-1:0] z_in,
   input  logic [BLOCK_W-1:0] v_in,
   input  logic [DIGIT_W-1:0] bits,
   output logic [BLOCK_W-1:0] z_out,
   output logic [BLOCK_W-1:0] v_out
);

   always_comb begin
      z_out = z_in;
      v_out = v_in;
      for (int i = DIGIT_W - 1; i >= 0; i--) begin
         if (bits[i]) z_out = z_out ^ v_out;
         // V.x in GCM bit order: right shift, fold the dropped bit back with R
         v_out = v_out[0] ? ((v_out >> 1) ^ GCM_R) : (v_out >> 1);
      end
   end

endmodule

// File: rtl/gcm_ghash_digit.sv
// GHASH accumulator: Y <= (Y ^ x) * H, computed over 128/DIGIT_W cycles.
// init reloads H and clears Y; next absorbs one block when ready.
module gcm_ghash_digit
   import gcm_pkg::*;
#(
   parameter int DIGIT_W = 1,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               init,
   input  logic               next,
   input  logic [127:0]       h0,
   input  logic [127:0]       x,
   output logic [127:0]       y,
   output logic               ready,
   output logic [CNT_W-1:0]   blk_cnt
);

   if (!gcm_digit_w_ok(DIGIT_W)) begin : g_bad_digit_w
      $error("gcm_ghash_digit: DIGIT_W must be 1, 2, 4, 8 or 16");
   end

   localparam logic [6:0] LAST_DIG = 7'(BLOCK_W / DIGIT_W - 1);

   gcm_state_e          state;
   logic [BLOCK_W-1:0]  h_q, v_q, z_q, xo_q, y_q;
   logic [BLOCK_W-1:0]  z_nxt, v_nxt;
   logic [6:0]          dig_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                ready_q;

   gcm_gf_digit_step #(.DIGIT_W(DIGIT_W)) u_step (
      .z_in  (z_q),
      .v_in  (v_q),
      .bits  (xo_q[BLOCK_W-1 -: DIGIT_W]),
      .z_out (z_nxt),
      .v_out (v_nxt)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         h_q     <= '0;
         v_q     <= '0;
         z_q     <= '0;
         xo_q    <= '0;
         y_q     <= '0;
         dig_q   <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
      end else if (init) begin
         // init aborts any multiply in flight; Y is not written from it
         state   <= ST_IDLE;
         h_q     <= h0;
         y_q     <= '0;
         dig_q   <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (next) begin
                  v_q     <= h_q;
                  xo_q    <= y_q ^ x;
                  z_q     <= '0;
                  dig_q   <= '0;
                  state   <= ST_MULT;
                  ready_q <= 1'b0;
               end
            end
            ST_MULT: begin
               z_q   <= z_nxt;
               v_q   <= v_nxt;
               xo_q  <= xo_q << DIGIT_W;
               dig_q <= dig_q + 7'd1;
               if (dig_q == LAST_DIG) begin
                  y_q     <= z_nxt;
                  cnt_q   <= cnt_q + CNT_W'(1);
                  state   <= ST_IDLE;
                  ready_q <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign y       = y_q;
   assign ready   = ready_q;
   assign blk_cnt = cnt_q;

endmodule

// File: doc/gcm_ghash_digit.md
GCM_GHASH_DIGIT -- requirements
Module: gcm_ghash_digit

Interface
REQ-001 The block SHALL have parameter DIGIT_W, default 1: bits of the multiplier operand consumed per clock; legal values 1, 2, 4, 8, 16.
REQ-002 The block SHALL have parameter CNT_W, default 32: width of the block counter.
REQ-003 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-005 The block SHALL have port init, input, 1: one-cycle pulse that loads h0 and clears the accumulator.
REQ-006 The block SHALL have port next, input, 1: one-cycle pulse that absorbs x into the accumulator.
REQ-007 The block SHALL have port h0, input, 128: hash subkey H, sampled on init.
REQ-008 The block SHALL have port x, input, 128: data block, sampled on an accepted next.
REQ-009 The block SHALL have port y, output, 128: accumulator Y (GHASH value).
REQ-010 The block SHALL have port ready, output, 1: high when idle and able to accept next.
REQ-011 The block SHALL have port blk_cnt, output, CNT_W: number of blocks absorbed since the last init.

Function
REQ-012 The block SHALL use two states: IDLE (ready=1) and MULT (ready=0).
REQ-013 In IDLE, when next=1 and init=0, the block SHALL latch V=H, latch operand Xo=Y xor x, clear Z, clear the digit counter, and go to MULT.
REQ-014 Each MULT cycle SHALL process DIGIT_W operand bits MSB-first (GCM bit 0 = bit 127), for each bit: if the bit is 1 then Z^=V; then V = V[0] ? (V>>1) xor R : V>>1, with R = 0xE1 followed by 120 zero bits.
REQ-015 MULT SHALL last exactly 128/DIGIT_W cycles; on the last cycle Y<=Z_final, blk_cnt increments, the state goes to IDLE, and ready is 1 on the following cycle.
REQ-016 y SHALL hold the previous value during MULT and update only on completion.
REQ-017 blk_cnt SHALL wrap from all-ones to 0 without any flag.
REQ-018 next while in MULT SHALL be ignored, with no queuing and no side effect.
REQ-019 init in any state SHALL load H=h0, clear Y, clear blk_cnt, and force IDLE, aborting any MULT in progress with no Y update.
REQ-020 When init and next are asserted in the same cycle, init SHALL win and next SHALL be dropped.
REQ-021 next with no prior init since reset SHALL operate with H=0, producing Y=0.

Reset
REQ-022 When reset_n=0 at a clock edge, the block SHALL set state=IDLE, y=0, H=0, V=0, Z=0, the digit counter=0, and blk_cnt=0, and ready SHALL be 1 from the first cycle after reset.
REQ-023 Reset SHALL take priority over init and next.

Structure
REQ-024 Package gcm_pkg SHALL hold BLOCK_W=128, the reduction constant R, the state enumeration typedef, and the legal-DIGIT_W check function.
REQ-025 The block SHALL have one combinational sub-module, gcm_gf_digit_step (parameter DIGIT_W; inputs Z, V, DIGIT_W operand bits; outputs Z', V'), instantiated once.
REQ-026 An illegal DIGIT_W SHALL produce an elaboration-time error.

Verification
REQ-027 Identity test: init with h0=80000000000000000000000000000000, then next with x=0123456789abcdeffedcba9876543210 -> y=0123456789abcdeffedcba9876543210 and blk_cnt=1.
REQ-028 GCM test case 2: h0=66e94bd4ef8a2c3b884cfa59ca342b2e; next x=0388dace60b6a392f328c2b971b2fe78 -> y=5e2ec746917062882c85b0685353deb7; then next x=00000000000000000000000000000080 -> y=f38cbb1ad69223dcc3457ae5b6b0f885 and blk_cnt=2.
REQ-029 Latency: for each DIGIT_W in {1,4,16}, ready SHALL be low for exactly 128, 32, and 8 cycles respectively after an accepted next, and the REQ-028 results SHALL match for all three.
REQ-030 Abort: init asserted mid-MULT with a new h0 -> y=0, blk_cnt=0, ready=1 on the next cycle; a following REQ-027 sequence SHALL give the correct result.
REQ-031 Collisions: next during MULT -> ignored, so blk_cnt advances by 1 only; init and next in the same cycle -> init only, y=0.
REQ-032 Reset: reset_n low mid-MULT -> y=0, blk_cnt=0, ready=1 one cycle after reset release; next before any init -> y=0.
